// File: rtl/my_package_pkg.sv
// my_package_pkg: shared ring/arbiter state types and the output decode table
package my_package_pkg;
  typedef enum logic [2:0] {
    FSM_ST0 = 3'd0,
    FSM_ST1 = 3'd1,
    FSM_ST2 = 3'd2,
    FSM_ST3 = 3'd3,
    FSM_ST4 = 3'd4,
    FSM_ST5 = 3'd5,
    FSM_ST6 = 3'd6,
    FSM_ST7 = 3'd7
  } FSM_States_t;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_STEP = 2'd1,
    ARB_HOLD = 2'd2
  } Arb_States_t;
  localparam logic [7:0] OUT_PAT = 8'b0101_1001;
  function automatic logic out_of(FSM_States_t s);
    return OUT_PAT[s];
  endfunction
endpackage

// File: rtl/ring_state_step.sv
// ring_state_step: ring position register with +/-1 mod-8 stepping, wrap pulse and out decode
module ring_state_step
  import my_package_pkg::FSM_States_t;
  import my_package_pkg::FSM_ST0;
  import my_package_pkg::FSM_ST7;
  import my_package_pkg::out_of;
(
  input  logic        c,
  input  logic        rst,
  input  logic        en,
  input  logic        dir,
  output FSM_States_t state,
  output logic        wrap,
  output logic        out
);
  FSM_States_t state_q, state_d;
  logic wrap_q, wrap_d, out_q, out_d;
  // a 3-bit ring has no illegal encodings, so modulo-8 arithmetic covers every step
  always_comb begin
    state_d = en ? FSM_States_t'(dir ? state_q + 3'd1 : state_q - 3'd1) : state_q;
    wrap_d = en & (dir ? state_q == FSM_ST7 : state_q == FSM_ST0);
    out_d = out_of(state_d);
  end
  // ring position register
  always_ff @(posedge c or posedge rst)
    if (rst) state_q <= FSM_ST0;
    else state_q <= state_d;
  // wrap pulse lines up with the first cycle of the wrapped state
  always_ff @(posedge c or posedge rst)
    if (rst) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  // decoded pattern registered alongside the state
  always_ff @(posedge c or posedge rst)
    if (rst) out_q <= 1'b1;
    else out_q <= out_d;
  assign state = state_q;
  assign wrap = wrap_q;
  assign out = out_q;
endmodule

// File: rtl/ring_step_arbiter.sv
// ring_step_arbiter: round-robin arbiter granting single ring steps with a hold window
module ring_step_arbiter
  import my_package_pkg::FSM_States_t;
  import my_package_pkg::Arb_States_t;
  import my_package_pkg::ARB_IDLE;
  import my_package_pkg::ARB_STEP;
  import my_package_pkg::ARB_HOLD;
#(
  parameter int N_REQ = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             c,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] dir,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output FSM_States_t      state,
  output logic             wrap,
  output logic             out
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  Arb_States_t arb_q, arb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, sel, idx;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic dirc_q, dirc_d, busy_q, busy_d, found, start;
  // round-robin search starting just after the last winner
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  // arbiter sequencing: requests only count while idle; hold counts down after each step
  always_comb begin
    start = arb_q == ARB_IDLE && |req;
    arb_d = start ? ARB_STEP :
            arb_q == ARB_STEP && HOLD_CYCLES != 0 ? ARB_HOLD :
            arb_q == ARB_HOLD && cnt_q != 4'd0 ? ARB_HOLD : ARB_IDLE;
    cnt_d = arb_q == ARB_STEP ? HOLD_INIT :
            arb_q == ARB_HOLD && cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
    win_d = start ? sel : win_q;
    dirc_d = start ? dir[sel] : dirc_q;
    ptr_d = arb_q == ARB_STEP ? win_q : ptr_q;
    gnt_d = start ? {{(N_REQ-1){1'b0}}, 1'b1} << sel : '0;
    busy_d = arb_d != ARB_IDLE;
  end
  // arbiter state
  always_ff @(posedge c or posedge rst)
    if (rst) arb_q <= ARB_IDLE;
    else arb_q <= arb_d;
  // hold window counter
  always_ff @(posedge c or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  // round-robin pointer, reset so requester 0 wins first
  always_ff @(posedge c or posedge rst)
    if (rst) ptr_q <= PW'(N_REQ - 1);
    else ptr_q <= ptr_d;
  // winner captured at selection
  always_ff @(posedge c or posedge rst)
    if (rst) win_q <= '0;
    else win_q <= win_d;
  // winner's direction frozen at selection
  always_ff @(posedge c or posedge rst)
    if (rst) dirc_q <= 1'b0;
    else dirc_q <= dirc_d;
  // grant, live only during the step cycle
  always_ff @(posedge c or posedge rst)
    if (rst) gnt_q <= '0;
    else gnt_q <= gnt_d;
  // busy across step and hold
  always_ff @(posedge c or posedge rst)
    if (rst) busy_q <= 1'b0;
    else busy_q <= busy_d;
  ring_state_step u_ring (
    .c(c),
    .rst(rst),
    .en(arb_q == ARB_STEP),
    .dir(dirc_q),
    .state(state),
    .wrap(wrap),
    .out(out)
  );
  assign gnt = gnt_q;
  assign busy = busy_q;
endmodule

// File: doc/ring_step_arbiter.md
RING_STEP_ARBITER -- requirements
Module: ring_step_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_CYCLES, default 2, idle cycles forced after each step; legal range 0..15.
REQ-003 c  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester step request, level, held until granted or withdrawn.
REQ-006 dir  input  N_REQ  per-requester direction: 1 = forward (STn->STn+1), 0 = backward.
REQ-007 gnt  output  N_REQ  one-hot grant, registered; all-zero when no grant.
REQ-008 busy  output  1  high while a step or its hold window is in progress.
REQ-009 state  output  FSM_States_t  current ring state, registered.
REQ-010 wrap  output  1  one-cycle pulse on ST7->ST0 forward or ST0->ST7 backward.
REQ-011 out  output  1  decoded pattern of state.

Function
REQ-012 Arbiter FSM states: ARB_IDLE, ARB_STEP, ARB_HOLD.
REQ-013 ARB_IDLE, any req high: select winner round-robin, searching from pointer+1 upward with wrap; next cycle ARB_STEP.
REQ-014 Winner's dir captured with the selection; later dir changes ignored.
REQ-015 ARB_STEP lasts exactly one cycle; gnt = one-hot of winner only in this cycle; pointer <= winner.
REQ-016 At end of ARB_STEP, state moves one position in captured direction, modulo 8.
REQ-017 Latency: req sampled in ARB_IDLE at cycle t -> gnt high at t+1 -> new state visible at t+2.
REQ-018 After ARB_STEP: ARB_HOLD for HOLD_CYCLES cycles, then ARB_IDLE; HOLD_CYCLES = 0 goes directly to ARB_IDLE.
REQ-019 req sampled only in ARB_IDLE; a request dropped before sampling is never granted.
REQ-020 A requester still holding req after ARB_HOLD competes again under round-robin; no back-to-back grant to the same index while another requester is pending.
REQ-021 busy = 1 in ARB_STEP and ARB_HOLD, 0 in ARB_IDLE.
REQ-022 wrap asserted in the same cycle the wrapped state value first appears on state.
REQ-023 out: ST0=1, ST1=0, ST2=0, ST3=1, ST4=1, ST5=0, ST6=1, ST7=0; any other encoding = 1.
REQ-024 Step from an illegal state encoding forces FSM_ST0, no wrap pulse.
REQ-025 Illegal arbiter encoding returns to ARB_IDLE next cycle with gnt = 0.

Reset
REQ-026 On rst: state = FSM_ST0, arbiter = ARB_IDLE, gnt = 0, busy = 0, wrap = 0, out = 1, hold counter = 0.
REQ-027 Round-robin pointer resets to N_REQ-1, so requester 0 wins first.
REQ-028 Reset asserted mid-step or mid-hold aborts the operation; no state update after release until a new grant.
REQ-029 First grant possible in the first ARB_IDLE cycle after rst deassertion.

Structure
REQ-030 my_package_pkg holds FSM_States_t (3-bit, FSM_ST0..FSM_ST7 = 0..7) and Arb_States_t.
REQ-031 Module imports both types by name from my_package_pkg.
REQ-032 Sub-module ring_state_step holds the state register, step logic (enable, dir), wrap detect and out decode.
REQ-033 Arbiter, pointer and hold counter live in ring_step_arbiter.
REQ-034 All state registers are voting-friendly: one always_ff per register, with the next-state logic reading only the voted copy.

Verification
REQ-035 Reset, then req=3'b001, dir=3'b001 for one sample -> gnt=001 at t+1, state=FSM_ST1 and out=0 at t+2, busy high 3 cycles.
REQ-036 req=3'b111 held, dir=3'b111, HOLD_CYCLES=2 -> grants 001,010,100,001 on every 4th cycle; state goes ST1,ST2,ST3,ST4.
REQ-037 From FSM_ST0, req=001, dir=000 -> state=FSM_ST7, wrap=1 for one cycle, out=0.
REQ-038 Seven forward steps from FSM_ST1 -> wrap pulses once at ST7->ST0, state=FSM_ST0, out=1.
REQ-039 rst asserted during ARB_HOLD after a grant from FSM_ST3 -> all outputs at reset values immediately; req=010 after release -> gnt=010.
REQ-040 HOLD_CYCLES=0, req=011 held -> grants alternate 001/010 every 2 cycles; busy toggles each cycle.
